// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the pipeline control blocks.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

endpackage

// File: rtl/forwarding_pkg.sv
// Forwarding scoreboard types: in-flight producer record, select encoding, helpers.
package forwarding_pkg;

    import cpu_types_pkg::*;

    // rem holds any producer latency up to 15 extra cycles; LAT_W must not exceed this.
    localparam int REM_W        = 4;
    localparam int FSEL_REGFILE = 0;

    typedef struct packed {
        logic             valid;
        logic             regwr;
        regbits_t         wsel;
        logic [REM_W-1:0] rem;
    } fwd_entry_t;

    function automatic int fsel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic fwd_entry_t entry_age(input fwd_entry_t e);
        fwd_entry_t a;
        a = e;
        if (a.rem != '0) begin
            a.rem = a.rem - REM_W'(1);
        end
        return a;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority search of one source register over the producer entries.
// Purely combinational; a younger match always shadows every older one.
module fwd_match
    import cpu_types_pkg::*;
    import forwarding_pkg::*;
#(
    parameter  int DEPTH  = 2,
    localparam int FSEL_W = fsel_width(DEPTH)
) (
    input  fwd_entry_t [DEPTH-1:0] i_entry,
    input  regbits_t               i_src,
    output logic                   o_hit,
    output logic                   o_ready,
    output logic [FSEL_W-1:0]      o_idx
);

    always_comb begin
        o_hit   = 1'b0;
        o_ready = 1'b0;
        o_idx   = '0;
        // Walk oldest to youngest so the youngest match is the last one written.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_entry[k].valid && i_entry[k].regwr &&
                (i_entry[k].wsel == i_src) && (i_src != '0)) begin
                o_hit   = 1'b1;
                o_ready = (i_entry[k].rem == '0);
                o_idx   = k[FSEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX-stage forwarding scoreboard: tracks producers EX+1..EX+DEPTH, drives per-source selects.
// Selects and hazard_stall are same-cycle combinational; freeze holds all state and the counter.
module fwd_scoreboard
    import cpu_types_pkg::*;
    import forwarding_pkg::*;
#(
    parameter  int NSRC   = 2,
    parameter  int DEPTH  = 2,
    parameter  int LAT_W  = 2,
    parameter  int CNT_W  = 32,
    localparam int FSEL_W = fsel_width(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ex_valid,
    input  logic                     ex_regwr,
    input  regbits_t                 ex_wsel,
    input  logic [LAT_W-1:0]         ex_lat,
    input  logic [NSRC*REG_W-1:0]    ex_src,
    input  logic                     freeze,
    input  logic                     flush,
    output logic [NSRC*FSEL_W-1:0]   fwdsel,
    output logic                     hazard_stall,
    output logic [CNT_W-1:0]         stall_count
);

    fwd_entry_t [DEPTH-1:0] r_entry;
    logic [CNT_W-1:0]       r_cnt;

    logic [NSRC-1:0]        w_hit;
    logic [NSRC-1:0]        w_ready;
    logic [FSEL_W-1:0]      w_idx [NSRC];
    logic                   w_issue;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_match #(
            .DEPTH   (DEPTH)
        ) u_match (
            .i_entry (r_entry),
            .i_src   (ex_src[i*REG_W +: REG_W]),
            .o_hit   (w_hit[i]),
            .o_ready (w_ready[i]),
            .o_idx   (w_idx[i])
        );
    end

    // A squashed EX instruction can never stall, even if its operands are pending.
    assign hazard_stall = ex_valid && !flush && (|(w_hit & ~w_ready));
    assign w_issue      = ex_valid && !flush && !hazard_stall;

    always_comb begin
        fwdsel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_hit[i] && w_ready[i] && !hazard_stall) begin
                fwdsel[i*FSEL_W +: FSEL_W] = w_idx[i] + FSEL_W'(1);
            end else begin
                fwdsel[i*FSEL_W +: FSEL_W] = FSEL_W'(FSEL_REGFILE);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_entry <= '0;
            r_cnt   <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_entry[k] <= entry_age(r_entry[k-1]);
            end
            if (w_issue) begin
                r_entry[0] <= '{valid: 1'b1,
                                regwr: ex_regwr,
                                wsel:  ex_wsel,
                                rem:   REM_W'(ex_lat)};
            end else begin
                r_entry[0] <= '0;
            end
            if (hazard_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed plus randomized bench for fwd_scoreboard against a producer-age reference model.
module tb_fwd_scoreboard;

    localparam int NSRC   = 2;
    localparam int DEPTH  = 2;
    localparam int LAT_W  = 2;
    localparam int CNT_W  = 4;
    localparam int FSEL_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   CLK;
    logic                   RST;
    logic                   ex_valid;
    logic                   ex_regwr;
    logic [4:0]             ex_wsel;
    logic [LAT_W-1:0]       ex_lat;
    logic [NSRC*5-1:0]      ex_src;
    logic                   freeze;
    logic                   flush;
    logic [NSRC*FSEL_W-1:0] fwdsel;
    logic                   hazard_stall;
    logic [CNT_W-1:0]       stall_count;

    fwd_scoreboard #(
        .NSRC         (NSRC),
        .DEPTH        (DEPTH),
        .LAT_W        (LAT_W),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ex_valid     (ex_valid),
        .ex_regwr     (ex_regwr),
        .ex_wsel      (ex_wsel),
        .ex_lat       (ex_lat),
        .ex_src       (ex_src),
        .freeze       (freeze),
        .flush        (flush),
        .fwdsel       (fwdsel),
        .hazard_stall (hazard_stall),
        .stall_count  (stall_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int vectors    = 0;
    int miscompares = 0;

    // A producer is known by its age: number of advancing edges since it left EX.
    // It sits at fwdsel = age, and its result exists once age-1 >= lat.
    typedef struct {
        bit regwr;
        int wsel;
        int lat;
        int age;
    } prod_t;

    prod_t prods[$];
    int    exp_sel [NSRC];
    bit    exp_stall;
    int    exp_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_eval();
        bit blocked;
        int best;
        int s;
        blocked = 0;
        for (int i = 0; i < NSRC; i++) begin
            s          = int'(ex_src[i*5 +: 5]);
            exp_sel[i] = 0;
            best       = -1;
            for (int p = 0; p < prods.size(); p++) begin
                if (prods[p].regwr && prods[p].wsel == s && s != 0) begin
                    if (best < 0) best = p;
                    else if (prods[p].age < prods[best].age) best = p;
                end
            end
            if (best >= 0) begin
                if (prods[best].age - 1 >= prods[best].lat) exp_sel[i] = prods[best].age;
                else blocked = 1;
            end
        end
        exp_stall = ex_valid && !flush && blocked;
        if (exp_stall) begin
            for (int i = 0; i < NSRC; i++) exp_sel[i] = 0;
        end
    endfunction

    function automatic void model_step();
        prod_t keep[$];
        prod_t t;
        if (RST) begin
            prods.delete();
            exp_cnt = 0;
        end else if (!freeze) begin
            if (exp_stall && exp_cnt < CNT_MAX) exp_cnt++;
            for (int p = 0; p < prods.size(); p++) begin
                if (prods[p].age < DEPTH) begin
                    t     = prods[p];
                    t.age = t.age + 1;
                    keep.push_back(t);
                end
            end
            if (ex_valid && !flush && !exp_stall) begin
                t.regwr = ex_regwr;
                t.wsel  = int'(ex_wsel);
                t.lat   = int'(ex_lat);
                t.age   = 1;
                keep.push_back(t);
            end
            prods = keep;
        end
    endfunction

    task automatic drv(input bit v, input bit rw, input int ws, input int lat,
                       input int s0, input int s1);
        ex_valid = v;
        ex_regwr = rw;
        ex_wsel  = 5'(ws);
        ex_lat   = LAT_W'(lat);
        ex_src   = {5'(s1), 5'(s0)};
    endtask

    task automatic apply();
        #2;
        model_eval();
        for (int i = 0; i < NSRC; i++) begin
            chk($sformatf("model_fwdsel%0d", i), 32'(fwdsel[i*FSEL_W +: FSEL_W]), exp_sel[i]);
        end
        chk("model_hazard_stall", 32'(hazard_stall), 32'(exp_stall));
        chk("model_stall_count", 32'(stall_count), exp_cnt);
    endtask

    task automatic tick();
        model_eval();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    initial begin
        bit done;
        RST    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        exp_cnt   = 0;
        exp_stall = 0;
        drv(0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        model_step();
        #1;
        RST = 1'b0;

        // Reset state
        apply();
        chk("rst_fwdsel", 32'(fwdsel), 0);
        chk("rst_stall", 32'(hazard_stall), 0);
        chk("rst_count", 32'(stall_count), 0);
        tick();

        // ALU producer forwarded from MEM, then WB, then regfile
        drv(1, 1, 3, 0, 0, 0); apply(); tick();
        drv(1, 0, 0, 0, 3, 0); apply();
        chk("t1_fwd0_mem", 32'(fwdsel[1:0]), 1);
        chk("t1_stall", 32'(hazard_stall), 0);
        tick();
        apply(); chk("t1_fwd0_wb", 32'(fwdsel[1:0]), 2); tick();
        apply(); chk("t1_fwd0_rf", 32'(fwdsel[1:0]), 0); tick();

        // Load-use stall on src1, then forward from WB
        drv(1, 1, 4, 1, 0, 0); apply(); tick();
        drv(1, 0, 0, 0, 0, 4); apply();
        chk("t2_stall", 32'(hazard_stall), 1);
        chk("t2_fwd1_blocked", 32'(fwdsel[3:2]), 0);
        chk("t2_count_before", 32'(stall_count), 0);
        tick();
        apply();
        chk("t2_count_after", 32'(stall_count), 1);
        chk("t2_stall_clear", 32'(hazard_stall), 0);
        chk("t2_fwd1_wb", 32'(fwdsel[3:2]), 2);
        tick();

        // Youngest of two writers wins; r0 never forwards
        drv(1, 1, 5, 0, 0, 0); apply(); tick();
        apply(); tick();
        drv(1, 0, 0, 0, 5, 5); apply();
        chk("t3_fwd0_young", 32'(fwdsel[1:0]), 1);
        chk("t3_fwd1_young", 32'(fwdsel[3:2]), 1);
        tick();
        drv(1, 1, 0, 0, 0, 0); apply(); tick();
        drv(1, 0, 0, 0, 0, 0); apply();
        chk("t3_r0_fwd", 32'(fwdsel), 0);
        chk("t3_r0_stall", 32'(hazard_stall), 0);
        tick();

        // Freeze holds a pending load and the counter
        drv(1, 1, 6, 1, 0, 0); apply(); tick();
        freeze = 1'b1;
        drv(1, 0, 0, 0, 6, 0);
        repeat (3) begin
            apply();
            chk("t4_frz_stall", 32'(hazard_stall), 1);
            chk("t4_frz_count", 32'(stall_count), 1);
            tick();
        end
        freeze = 1'b0;
        apply(); chk("t4_stall", 32'(hazard_stall), 1); tick();
        apply();
        chk("t4_released", 32'(hazard_stall), 0);
        chk("t4_fwd0_wb", 32'(fwdsel[1:0]), 2);
        chk("t4_count", 32'(stall_count), 2);
        tick();

        // Flush beats the hazard
        drv(1, 1, 6, 1, 0, 0); apply(); tick();
        flush = 1'b1;
        drv(1, 0, 0, 0, 6, 0); apply();
        chk("t5_flush_stall", 32'(hazard_stall), 0);
        chk("t5_flush_fwd0", 32'(fwdsel[1:0]), 0);
        tick();
        flush = 1'b0;
        apply();
        chk("t5_fwd0_wb", 32'(fwdsel[1:0]), 2);
        chk("t5_count", 32'(stall_count), 2);
        tick();

        // Reset overrides freeze
        drv(1, 1, 8, 0, 0, 0); apply(); tick();
        freeze = 1'b1;
        RST    = 1'b1;
        drv(1, 0, 0, 0, 8, 0); apply();
        chk("t6_pre_fwd0", 32'(fwdsel[1:0]), 1);
        tick();
        freeze = 1'b0;
        RST    = 1'b0;
        apply();
        chk("t6_rst_fwd0", 32'(fwdsel[1:0]), 0);
        chk("t6_rst_count", 32'(stall_count), 0);
        chk("t6_rst_stall", 32'(hazard_stall), 0);
        tick();

        // Long-latency producers leave before ready; counter saturates
        repeat (10) begin
            drv(1, 1, 7, 3, 0, 0); apply(); tick();
            drv(1, 0, 0, 0, 7, 0);
            done = 0;
            for (int n = 0; n < 6 && !done; n++) begin
                apply();
                if (!exp_stall) done = 1;
                else tick();
            end
            chk("sat_drain_stall", 32'(hazard_stall), 0);
            chk("sat_drain_fwd0", 32'(fwdsel[1:0]), 0);
            tick();
        end
        apply();
        chk("sat_count", 32'(stall_count), CNT_MAX);
        tick();

        // Randomized traffic
        repeat (400) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 7), $urandom_range(0, 7));
            freeze = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            RST    = ($urandom_range(0, 49) == 0);
            apply();
            tick();
        end
        RST    = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
